// File: rtl/node_bits_collect_pkg.sv
// node_bits_collect_pkg
// Shared definitions for the node bit collector and its G8 transform.
//   NODE_BIT_NUM        : bits per node decision (8)
//   func_type_bit_bus_t : one node hard-decision word
//   nbc_state_t         : collector states NBC_IDLE / NBC_COLLECT / NBC_DONE
package node_bits_collect_pkg;

    localparam int NODE_BIT_NUM = 8;

    typedef logic [NODE_BIT_NUM-1:0] func_type_bit_bus_t;

    typedef enum logic [1:0] {
        NBC_IDLE    = 2'd0,
        NBC_COLLECT = 2'd1,
        NBC_DONE    = 2'd2
    } nbc_state_t;

endpackage

// File: rtl/node_bits_collect_xform8.sv
// polar_xform8
// Combinational 8-bit polar transform u = x * G8, G8 = F (x) F (x) F.
// G8 is its own inverse, so the same block serves the encoder and the
// partial-sum path.
// Ports:
//   x_in  [7:0] : codeword-domain word, x_in[7] is position 0
//   u_out [7:0] : information-domain word, same bit placement
module polar_xform8
    import node_bits_collect_pkg::*;
(
    input  logic [NODE_BIT_NUM-1:0] x_in,
    output logic [NODE_BIT_NUM-1:0] u_out
);

    // Three XOR butterfly stages on position order p0..p7. Arrays are indexed
    // by position, so bit 7 of the bus maps to p0. At each stage the element
    // with the lower position (upper in the butterfly drawing) absorbs its
    // partner at distance 4, then 2, then 1.
    logic [7:0] s0, s1, s2, s3;

    always_comb begin
        s0 = '0;
        for (int p = 0; p < 8; p++) begin
            s0[p] = x_in[7-p];
        end

        s1 = s0;
        for (int p = 0; p < 4; p++) begin
            s1[p] = s0[p] ^ s0[p+4];
        end

        s2 = s1;
        for (int p = 0; p < 8; p++) begin
            if ((p & 2) == 0) begin
                s2[p] = s1[p] ^ s1[p+2];
            end
        end

        s3 = s2;
        for (int p = 0; p < 8; p++) begin
            if ((p & 1) == 0) begin
                s3[p] = s2[p] ^ s2[p+1];
            end
        end

        u_out = '0;
        for (int p = 0; p < 8; p++) begin
            u_out[7-p] = s3[p];
        end
    end

endmodule

// File: rtl/node_bits_collect.sv
// node_bits_collect
// Collects 8-bit node hard decisions into an N-bit codeword buffer (x_frame)
// and its information-domain image (u_frame), forwards each accepted word as
// a partial-sum word, and pulses frame_done when the last node lands.
// Optional feature: define NODE_PSUM_REG_OUT_EN to add an extra register
// stage on psum_out/psum_idx/psum_vld/frame_done (psum latency 2).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   frame_start          : pulse that begins or aborts/restarts a frame
//   bit_vld, bit_in[7:0] : node decision input (bit_in[7] is position 0)
//   bit_rdy              : block accepts a node (COLLECT state only)
//   psum_vld/out/idx     : registered copy of the accepted word and its slot
//   x_frame, u_frame     : assembled frame buffers, node k at [N-1-8k -: 8]
//   frame_done           : single-cycle frame completion pulse
//   ovf_err              : sticky, node offered while not ready
module node_bits_collect
    import node_bits_collect_pkg::*;
#(
    parameter int N        = 64,
    parameter int NODE_NUM = N / 8,
    localparam int IDX_W   = $clog2(NODE_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    bit_vld,
    input  logic [NODE_BIT_NUM-1:0] bit_in,
    output logic                    bit_rdy,
    output logic                    psum_vld,
    output logic [NODE_BIT_NUM-1:0] psum_out,
    output logic [IDX_W-1:0]        psum_idx,
    output logic [N-1:0]            x_frame,
    output logic [N-1:0]            u_frame,
    output logic                    frame_done,
    output logic                    ovf_err
);

    nbc_state_t         state;
    logic [IDX_W-1:0]   node_cnt;
    func_type_bit_bus_t u_word;

    logic                    psum_vld_s1;
    logic                    frame_done_s1;
    logic [NODE_BIT_NUM-1:0] psum_out_s1;
    logic [IDX_W-1:0]        psum_idx_s1;

    polar_xform8 u_xform (
        .x_in  (bit_in),
        .u_out (u_word)
    );

    // Collector FSM and frame buffers. bit_rdy is registered next to the
    // state so it never depends on bit_vld combinationally. frame_start has
    // priority over everything: it restarts the frame, clears the buffers
    // and the sticky error, and discards any node offered in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= NBC_IDLE;
            bit_rdy       <= 1'b0;
            node_cnt      <= '0;
            x_frame       <= '0;
            u_frame       <= '0;
            ovf_err       <= 1'b0;
            psum_vld_s1   <= 1'b0;
            frame_done_s1 <= 1'b0;
            psum_out_s1   <= '0;
            psum_idx_s1   <= '0;
        end else begin
            psum_vld_s1   <= 1'b0;
            frame_done_s1 <= 1'b0;
            if (frame_start) begin
                state    <= NBC_COLLECT;
                bit_rdy  <= 1'b1;
                node_cnt <= '0;
                x_frame  <= '0;
                u_frame  <= '0;
                ovf_err  <= 1'b0;
            end else begin
                if (bit_vld && !bit_rdy) begin
                    ovf_err <= 1'b1;
                end
                case (state)
                    NBC_IDLE: begin
                        bit_rdy <= 1'b0;
                    end
                    NBC_COLLECT: begin
                        if (bit_vld) begin
                            for (int k = 0; k < NODE_NUM; k++) begin
                                if (node_cnt == IDX_W'(k)) begin
                                    x_frame[N-1-8*k -: 8] <= bit_in;
                                    u_frame[N-1-8*k -: 8] <= u_word;
                                end
                            end
                            psum_vld_s1 <= 1'b1;
                            psum_out_s1 <= bit_in;
                            psum_idx_s1 <= node_cnt;
                            if (node_cnt == IDX_W'(NODE_NUM - 1)) begin
                                node_cnt      <= '0;
                                state         <= NBC_DONE;
                                bit_rdy       <= 1'b0;
                                frame_done_s1 <= 1'b1;
                            end else begin
                                node_cnt <= node_cnt + 1'b1;
                            end
                        end
                    end
                    NBC_DONE: begin
                        state   <= NBC_IDLE;
                        bit_rdy <= 1'b0;
                    end
                    default: begin
                        state   <= NBC_IDLE;
                        bit_rdy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NODE_PSUM_REG_OUT_EN
    // Extra output stage. A frame_start drops whatever is in flight so an
    // aborted frame never reports a late partial sum or completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_vld   <= 1'b0;
            frame_done <= 1'b0;
            psum_out   <= '0;
            psum_idx   <= '0;
        end else begin
            psum_out <= psum_out_s1;
            psum_idx <= psum_idx_s1;
            if (frame_start) begin
                psum_vld   <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                psum_vld   <= psum_vld_s1;
                frame_done <= frame_done_s1;
            end
        end
    end
`else
    assign psum_vld   = psum_vld_s1;
    assign frame_done = frame_done_s1;
    assign psum_out   = psum_out_s1;
    assign psum_idx   = psum_idx_s1;
`endif

endmodule

// File: tb/tb_node_bits_collect.sv
// tb_node_bits_collect
// Scoreboard bench for node_bits_collect (N=64). The driver updates a
// behavioural frame model and queues expected partial sums; a negedge
// monitor pops and compares whenever psum_vld is high.
module tb_node_bits_collect;

    localparam int N     = 64;
    localparam int NODES = 8;
`ifdef NODE_PSUM_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int ST_IDLE    = 0;
    localparam int ST_COLLECT = 1;
    localparam int ST_DONE    = 2;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          bit_vld;
    logic [7:0]    bit_in;
    logic          bit_rdy;
    logic          psum_vld;
    logic [7:0]    psum_out;
    logic [2:0]    psum_idx;
    logic [N-1:0]  x_frame;
    logic [N-1:0]  u_frame;
    logic          frame_done;
    logic          ovf_err;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         done;
        int         due;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int neg_cnt = 0;

    int           m_state = ST_IDLE;
    int           m_cnt = 0;
    logic [N-1:0] m_x = '0;
    logic [N-1:0] m_u = '0;
    logic         m_ovf = 1'b0;

    node_bits_collect #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bit_vld     (bit_vld),
        .bit_in      (bit_in),
        .bit_rdy     (bit_rdy),
        .psum_vld    (psum_vld),
        .psum_out    (psum_out),
        .psum_idx    (psum_idx),
        .x_frame     (x_frame),
        .u_frame     (u_frame),
        .frame_done  (frame_done),
        .ovf_err     (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // u = x * F(x)3: information bit p is the XOR of every codeword bit q
    // whose position index contains all the index bits of p.
    function automatic logic [7:0] g8Ref(input logic [7:0] x);
        logic [7:0] u;
        logic b;
        u = '0;
        for (int p = 0; p < 8; p++) begin
            b = 1'b0;
            for (int q = 0; q < 8; q++) begin
                if ((q & p) == p) b = b ^ x[7-q];
            end
            u[7-p] = b;
        end
        return u;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model update for one clock edge's inputs.
    task automatic modelStep(input logic s, input logic v, input logic [7:0] d);
        int prev;
        exp_t e;
        prev = m_state;
        if (s) begin
            m_state = ST_COLLECT;
            m_cnt   = 0;
            m_x     = '0;
            m_u     = '0;
            m_ovf   = 1'b0;
            while (sb.size() > 0 && sb[sb.size()-1].due > neg_cnt) void'(sb.pop_back());
        end else begin
            if (prev == ST_DONE) m_state = ST_IDLE;
            if (v) begin
                if (prev == ST_COLLECT) begin
                    m_x[N-1-8*m_cnt -: 8] = d;
                    m_u[N-1-8*m_cnt -: 8] = g8Ref(d);
                    e.idx  = m_cnt;
                    e.data = d;
                    e.done = (m_cnt == NODES - 1);
                    e.due  = neg_cnt + LAT;
                    sb.push_back(e);
                    m_cnt++;
                    if (m_cnt == NODES) begin
                        m_cnt   = 0;
                        m_state = ST_DONE;
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
        frame_start = s;
        bit_vld     = v;
        bit_in      = d;
        @(posedge clk);
        modelStep(s, v, d);
        #1;
        frame_start = 1'b0;
        bit_vld     = 1'b0;
        bit_in      = '0;
    endtask

    task automatic checkFrames(input string tag);
        checkOutput({tag, "_x_frame"}, x_frame, m_x);
        checkOutput({tag, "_u_frame"}, u_frame, m_u);
        checkOutput({tag, "_ovf_err"}, ovf_err, m_ovf);
    endtask

    // Scoreboard monitor: compares every presented partial sum against the
    // oldest queued expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            neg_cnt++;
            if (psum_vld) begin
                if (sb.size() == 0) begin
                    checkOutput("psum_unexpected", {56'd0, psum_out}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("psum_idx", psum_idx, e.idx);
                    checkOutput("psum_out", psum_out, e.data);
                    checkOutput("frame_done", frame_done, e.done);
                    checkOutput("psum_cycle", neg_cnt, e.due);
                end
            end else begin
                if (sb.size() > 0 && sb[0].due <= neg_cnt) begin
                    checkOutput("psum_missing", 64'd0, {56'd0, sb[0].data});
                    void'(sb.pop_front());
                end
                if (frame_done) checkOutput("frame_done_stray", frame_done, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] d;
        int r;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        bit_vld     = 1'b0;
        bit_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_bit_rdy", bit_rdy, 1'b0);
        checkOutput("rst_psum_vld", psum_vld, 1'b0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_ovf_err", ovf_err, 1'b0);
        checkOutput("rst_psum_out", psum_out, 8'h00);
        checkOutput("rst_psum_idx", psum_idx, 3'd0);
        checkOutput("rst_x_frame", x_frame, 64'd0);
        checkOutput("rst_u_frame", u_frame, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back frame 00..07");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("start_bit_rdy", bit_rdy, 1'b1);
        for (int i = 0; i < NODES; i++) applyStimulus(1'b0, 1'b1, 8'(i));
        checkOutput("b2b_bit_rdy_done", bit_rdy, 1'b0);
        checkOutput("b2b_x_first", x_frame[63:56], 8'h00);
        checkOutput("b2b_x_last", x_frame[7:0], 8'h07);
        checkFrames("b2b");
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] single-node transforms");
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("g8_80", u_frame[63:56], 8'h80);
        checkOutput("g8_01", u_frame[55:48], 8'hFF);
        checkOutput("g8_FF", u_frame[47:40], 8'h01);
        checkOutput("g8_00", u_frame[39:32], 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        checkFrames("xform");
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] gapped frame, then ovf in DONE and IDLE");
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < NODES; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            applyStimulus(1'b0, 1'b0, 8'h00);
            applyStimulus(1'b0, 1'b1, 8'(i));
        end
        checkOutput("gap_x_frame", x_frame, 64'h0001020304050607);
        applyStimulus(1'b0, 1'b1, 8'hAA);
        checkOutput("ovf_done_cycle", ovf_err, 1'b1);
        checkFrames("ovf_done");
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ovf_sticky", ovf_err, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkFrames("ovf_idle");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("ovf_cleared", ovf_err, 1'b0);

        $display("[TB] abort after 5 nodes");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("abort_x_clear", x_frame, 64'd0);
        checkOutput("abort_u_clear", u_frame, 64'd0);
        for (int i = 0; i < NODES; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        checkFrames("abort_new");
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            for (int it = 0; it < 300 && m_state == ST_COLLECT; it++) begin
                r = $urandom_range(0, 39);
                d = 8'($urandom);
                if (r == 0) applyStimulus(1'b1, 1'b1, d);
                else if (r < 12) applyStimulus(1'b0, 1'b0, d);
                else applyStimulus(1'b0, 1'b1, d);
                checkOutput("rand_bit_rdy", bit_rdy, m_state == ST_COLLECT);
            end
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            checkFrames("rand");
        end

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        m_state = ST_IDLE;
        m_cnt   = 0;
        m_x     = '0;
        m_u     = '0;
        m_ovf   = 1'b0;
        checkOutput("arst_bit_rdy", bit_rdy, 1'b0);
        checkOutput("arst_psum_vld", psum_vld, 1'b0);
        checkOutput("arst_psum_out", psum_out, 8'h00);
        checkOutput("arst_psum_idx", psum_idx, 3'd0);
        checkOutput("arst_frame_done", frame_done, 1'b0);
        checkFrames("arst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkOutput("arst_idle_ovf", ovf_err, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        checkOutput("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_bits_collect.md
# node_bits_collect

Frame-level collector placed directly downstream of the 8-bit node decoders, including the SPC-8 type-3 unit. Each accepted 8-bit hard decision is a codeword-domain estimate x. The block forwards it as a registered partial-sum word for the LLR g-stage. It also converts x to the information domain (u = x·G8, with G8 = F⊗3 self-inverse) and assembles both x and u into N-bit frame buffers. It reports frame completion to the decoder controller.

## Interface
- `N`, default 64: frame length in bits; a multiple of 8, at least 16.
- `NODE_NUM`, default N/8: nodes per frame.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `frame_start`, input, 1: single-cycle pulse that begins or restarts a frame.
- `bit_vld`, input, 1: the node decision on `bit_in` is valid.
- `bit_in`, input, `FUNC_TYPE_BIT_BUS` [7:0]: node decision. `bit_in[7]` is node position 0; `bit_in[0]` is position 7.
- `bit_rdy`, output, 1: the block can accept a node.
- `psum_vld`, output, 1: `psum_out` and `psum_idx` are valid.
- `psum_out`, output, 8: registered copy of the accepted x word.
- `psum_idx`, output, log2(NODE_NUM): index of the node in `psum_out`.
- `x_frame`, output, N: assembled codeword estimate. Node k occupies [N-1-8k -: 8].
- `u_frame`, output, N: assembled information-domain bits, same placement as `x_frame`.
- `frame_done`, output, 1: single-cycle pulse once the last node has been written.
- `ovf_err`, output, 1: sticky flag for a node that arrived while the block was not ready.

## Operation
- States:
  - IDLE: `bit_rdy` = 0.
  - COLLECT: `bit_rdy` = 1.
  - DONE: `bit_rdy` = 0; lasts exactly one cycle.
- Transitions:
  - IDLE → COLLECT on `frame_start`.
  - COLLECT → DONE when node NODE_NUM-1 is accepted.
  - DONE → IDLE unconditionally.
- Accept: a node is accepted when `bit_vld` && `bit_rdy`. The accepted x is written at slot `node_cnt`, u = G8(x) is written into `u_frame`, and `node_cnt` increments.
- G8 is a 3-stage XOR butterfly on position order p0..p7:
  - stage 1: pairs (p, p+4);
  - stage 2: pairs (p, p+2);
  - stage 3: pairs (p, p+1);
  - at each stage the upper element ^= the lower one. Purely combinational.
- `frame_start` in COLLECT or DONE aborts the frame:
  - `node_cnt` → 0, both buffers cleared, state → COLLECT;
  - no `frame_done` is issued;
  - a `bit_vld` in the same cycle is discarded.
- `frame_start` in IDLE together with `bit_vld`: start takes effect and the data is ignored, because `bit_rdy` was 0.
- `bit_vld` while `bit_rdy` = 0 sets `ovf_err`; the data is dropped. `ovf_err` clears only on reset or `frame_start`.
- Buffers hold their contents after DONE until the next `frame_start`.

## Timing
- Reset values: state IDLE; `bit_rdy`, `psum_vld`, `frame_done` and `ovf_err` are 0; `psum_out`, `psum_idx`, `x_frame`, `u_frame` and `node_cnt` are 0.
- Throughput: one node per cycle while in COLLECT.
- `psum_vld`, `psum_out`, `psum_idx`, `x_frame` and `u_frame` update one cycle after the accept edge (latency 1).
- `frame_done` is high in the DONE cycle, which is the cycle after the last accept, coincident with the last `psum_vld`.
- `bit_rdy` is driven by state only and has no combinational path from `bit_vld`.
- Reset mid-frame returns the block to reset values immediately, asynchronously.

## Configuration
- `NODE_PSUM_REG_OUT_EN` defined:
  - `psum_out`, `psum_idx`, `psum_vld` and `frame_done` get an extra register stage;
  - psum latency becomes 2 and `frame_done` asserts one cycle after DONE;
  - the state machine is unchanged;
  - a `frame_start` abort kills the in-flight stage.
- Not defined: latency 1 as above.

## Structure
- Add to `defines.v`: `FUNC_TYPE_BIT_BUS`, `NODE_BIT_NUM` (8), and the state encodings `NBC_IDLE`, `NBC_COLLECT`, `NBC_DONE`.
- One sub-module: `polar_xform8`, the combinational 8-bit G8 butterfly. It is reusable by the encoder and by the partial-sum path.

## Test plan
- Reset, `frame_start`, then 8 nodes (N=64) on consecutive cycles with x = 8'h00..8'h07 → `psum_idx` 0..7 with one-cycle latency; `frame_done` pulses exactly once in the cycle after the 8th accept; `x_frame[63:56]` = 8'h00 and `x_frame[7:0]` = 8'h07.
- Single-node transforms: x = 8'h80 → u = 8'h80; x = 8'h01 → u = 8'hFF; x = 8'hFF → u = 8'h01; x = 8'h00 → u = 8'h00.
- Gapped `bit_vld` (every third cycle) → the same `x_frame` as the back-to-back case; `frame_done` follows the last accept by 1 cycle.
- `frame_start` after 5 nodes, then 8 new nodes → no `frame_done` for the aborted frame; buffers contain only the new frame; `psum_idx` restarts at 0.
- `bit_vld` in IDLE, and `bit_vld` in the DONE cycle → `ovf_err` = 1 and stays 1; data not written; the next `frame_start` clears it.
- Assert `rst_n` low in the middle of a frame → all outputs 0 asynchronously and state IDLE. With `NODE_PSUM_REG_OUT_EN` defined, the first test shows psum latency 2.
